// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_ADDW   = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LLB    = 4'h8;
  localparam logic [3:0] OP_LHB    = 4'h9;
  localparam logic [3:0] OP_MUL    = 4'hA;

  // flags bus ordering is {Z,V,N}
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  // Which architectural flag bits an opcode commits when its result is consumed.
  function automatic logic [2:0] flag_wr_mask(input logic [3:0] op);
    logic [2:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB: m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier: one partial product per cycle, WIDTH iterations,
// done pulses for one cycle after the last iteration; clear aborts immediately.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else if (clear) begin
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
        product <= '0;
        cnt     <= CNT_W'(WIDTH - 1);
        busy    <= 1'b1;
      end else if (busy) begin
        // Always run the full count so latency is independent of operand values
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU for EX: single-cycle ops return next cycle, MUL after WIDTH+1 cycles;
// result held until out_ready, architectural {Z,V,N} committed at the output handshake.
module alu_mc_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int LANE_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z_set,
  output logic             v_set,
  output logic             n_set,
  output logic             err,
  output logic [2:0]       flags
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int               NLANE = WIDTH / LANE_W;

  state_t               state;
  logic [3:0]           out_op;
  logic                 accept, deq, mul_start;
  logic                 mul_busy, mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [SHAMT_W-1:0]   sh;
  logic [WIDTH-1:0]     sum, diff, padd_res;
  logic                 add_ovf, sub_ovf;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_v, alu_err;
  logic [2:0]           wr_mask;

  assign in_ready  = (state == ST_IDLE) && !mul_busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign mul_start = accept && (opcode == OP_MUL) && !flush;
  assign wr_mask   = flag_wr_mask(out_op);

  assign sh      = b[SHAMT_W-1:0];
  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Per-lane saturating adds; carries never cross lane boundaries
  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    logic [LANE_W-1:0] la, lb, ls;
    logic              lovf;
    assign la   = a[i*LANE_W +: LANE_W];
    assign lb   = b[i*LANE_W +: LANE_W];
    assign ls   = la + lb;
    assign lovf = (la[LANE_W-1] == lb[LANE_W-1]) && (ls[LANE_W-1] != la[LANE_W-1]);
    assign padd_res[i*LANE_W +: LANE_W] =
      !lovf ? ls : (la[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}});
  end

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = add_ovf ? (a[WIDTH-1] ? SMIN : SMAX) : sum;
        alu_v   = add_ovf;
      end
      OP_SUB: begin
        alu_res = sub_ovf ? (a[WIDTH-1] ? SMIN : SMAX) : diff;
        alu_v   = sub_ovf;
      end
      OP_XOR:    alu_res = a ^ b;
      OP_ADDW:   alu_res = sum;
      OP_SLL:    alu_res = a << sh;
      OP_SRA:    alu_res = $signed(a) >>> sh;
      OP_ROR:    alu_res = (a >> sh) | (a << (WIDTH - int'(sh)));
      OP_PADDSB: alu_res = padd_res;
      OP_LLB:    alu_res = {a[WIDTH-1:WIDTH/2], b[WIDTH/2-1:0]};
      OP_LHB:    alu_res = {b[WIDTH/2-1:0], a[WIDTH/2-1:0]};
      default:   alu_err = 1'b1;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_op    <= OP_ADD;
      result    <= '0;
      z_set     <= 1'b0;
      v_set     <= 1'b0;
      n_set     <= 1'b0;
      err       <= 1'b0;
      flags     <= 3'b000;
    end else if (flush) begin
      out_valid <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      if (deq) begin
        out_valid <= 1'b0;
        if (!err) flags <= (flags & ~wr_mask) | ({z_set, v_set, n_set} & wr_mask);
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              state <= ST_MUL;
            end else begin
              out_valid <= 1'b1;
              out_op    <= opcode;
              result    <= alu_res;
              err       <= alu_err;
              v_set     <= alu_v;
              z_set     <= !alu_err && (alu_res == '0);
              n_set     <= alu_res[WIDTH-1];
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            out_op    <= OP_MUL;
            result    <= mul_prod[WIDTH-1:0];
            err       <= 1'b0;
            v_set     <= |mul_prod[2*WIDTH-1:WIDTH];
            z_set     <= (mul_prod[WIDTH-1:0] == '0);
            n_set     <= mul_prod[WIDTH-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc_unit.sv
// Directed self-checking bench for alu_mc_unit (WIDTH=16 main instance, WIDTH=32 lane check).
module tb_alu_mc_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic        z_set, v_set, n_set, err;
  logic [3:0]  opcode;
  logic [15:0] a, b, result;
  logic [2:0]  flags;

  logic        iv32, ir32, ov32, z32, v32, n32, e32;
  logic [3:0]  opc32;
  logic [31:0] a32, b32, r32;
  logic [2:0]  f32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mc_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .z_set(z_set), .v_set(v_set), .n_set(n_set), .err(err), .flags(flags)
  );

  alu_mc_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(iv32), .in_ready(ir32),
    .opcode(opc32), .a(a32), .b(b32), .out_valid(ov32), .out_ready(1'b1),
    .result(r32), .z_set(z32), .v_set(v32), .n_set(n32), .err(e32), .flags(f32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    opcode   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int  cyc;
    logic bad;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 4'h0; a = '0; b = '0;
    iv32 = 1'b0; opc32 = 4'h0; a32 = '0; b32 = '0;
    #2 rst_n = 1'b0;
    step(); step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'h0);
    chk("rst_flags", {29'b0, flags}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    // WIDTH=32 lane saturation
    opc32 = 4'h7; a32 = 32'h7000_00F7; b32 = 32'h1000_00F1; iv32 = 1'b1;
    step();
    iv32 = 1'b0;
    chk("w32_paddsb_res", r32, 32'h7000_00E7);
    chk("w32_paddsb_vld", {31'b0, ov32}, 32'd1);

    issue(4'h0, 16'h7FFF, 16'h0001);
    chk("add_sat_res", {16'b0, result}, 32'h7FFF);
    chk("add_sat_vzn", {29'b0, v_set, n_set, z_set}, 32'b100);
    chk("add_out_valid", {31'b0, out_valid}, 32'd1);
    step();
    chk("add_flags", {29'b0, flags}, 32'b010);

    issue(4'h1, 16'h8000, 16'h0001);
    chk("sub_sat_res", {16'b0, result}, 32'h8000);
    chk("sub_sat_v", {31'b0, v_set}, 32'd1);
    step();
    chk("sub_flags", {29'b0, flags}, 32'b011);

    issue(4'h3, 16'hFFFF, 16'h0002);
    chk("addw_res", {16'b0, result}, 32'h0001);
    chk("addw_v", {31'b0, v_set}, 32'd0);
    step();
    chk("addw_flags", {29'b0, flags}, 32'b011);

    issue(4'h2, 16'h5555, 16'h5555);
    chk("xor_res", {16'b0, result}, 32'h0000);
    chk("xor_z", {31'b0, z_set}, 32'd1);
    step();
    chk("xor_flags", {29'b0, flags}, 32'b111);

    issue(4'h6, 16'h8001, 16'h0001);
    chk("ror_res", {16'b0, result}, 32'hC000);
    step();
    chk("ror_flags", {29'b0, flags}, 32'b011);

    issue(4'h5, 16'h8000, 16'h000F);
    chk("sra_res", {16'b0, result}, 32'hFFFF);
    issue(4'h4, 16'h1234, 16'h0000);
    chk("sll0_res", {16'b0, result}, 32'h1234);
    issue(4'h8, 16'hABCD, 16'h1234);
    chk("llb_res", {16'b0, result}, 32'hAB34);
    issue(4'h9, 16'hABCD, 16'h1234);
    chk("lhb_res", {16'b0, result}, 32'h34CD);
    issue(4'h7, 16'h7F1F, 16'h1111);
    chk("paddsb_res", {16'b0, result}, 32'h7020);

    issue(4'hE, 16'h1234, 16'h5678);
    chk("inv_err", {31'b0, err}, 32'd1);
    chk("inv_res", {16'b0, result}, 32'h0);
    chk("inv_z", {31'b0, z_set}, 32'd0);
    step();
    chk("inv_flags", {29'b0, flags}, 32'b011);

    // MUL latency and in_ready stall
    issue(4'hA, 16'h0100, 16'h0100);
    cyc = 0; bad = 1'b0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
      if (!out_valid && in_ready) bad = 1'b1;
    end
    chk("mul_latency", cyc, 32'd17);
    chk("mul_in_ready_low", {31'b0, bad}, 32'd0);
    chk("mul_res", {16'b0, result}, 32'h0000);
    chk("mul_vz", {30'b0, v_set, z_set}, 32'b11);
    step();
    chk("mul_flags", {29'b0, flags}, 32'b011);

    issue(4'hA, 16'h0003, 16'h0005);
    cyc = 0;
    while (!out_valid && cyc < 40) begin step(); cyc++; end
    chk("mul2_res", {16'b0, result}, 32'h000F);
    chk("mul2_v", {31'b0, v_set}, 32'd0);
    step();

    // Backpressure hold
    out_ready = 1'b0;
    issue(4'h0, 16'h0001, 16'h0002);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {13'b0, out_valid, in_ready, flags, result}, {13'b0, 1'b1, 1'b0, 3'b011, 16'h0003});
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_vld", {31'b0, out_valid}, 32'd0);
    chk("bp_release_flags", {29'b0, flags}, 32'b000);

    // Back-to-back: dequeue and accept in the same cycle
    opcode = 4'h0; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    step();
    chk("b2b_first", {16'b0, result}, 32'h0002);
    opcode = 4'h1; a = 16'h0009; b = 16'h0003;
    step();
    in_valid = 1'b0;
    chk("b2b_second", {15'b0, out_valid, result}, {15'b0, 1'b1, 16'h0006});
    step();

    // Flush at MUL cycle 8
    issue(4'hA, 16'h0003, 16'h0005);
    for (int i = 0; i < 7; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_vld", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); if (out_valid) bad = 1'b1; end
    chk("flush_no_result", {31'b0, bad}, 32'd0);
    chk("flush_flags", {29'b0, flags}, 32'b000);

    // Async reset mid-MUL
    issue(4'h0, 16'h7FFF, 16'h0001);
    step();
    chk("pre_rst_flags", {29'b0, flags}, 32'b010);
    issue(4'hA, 16'h0003, 16'h0005);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {12'b0, out_valid, in_ready, v_set, flags, result}, {12'b0, 1'b0, 1'b1, 1'b0, 3'b000, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin step(); if (out_valid) bad = 1'b1; end
    chk("arst_no_result", {31'b0, bad}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
